tar_axil_arbiter: RTL
=====================

TAR_AXIL_ARBITER -- requirements
Module: tar_axil_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, AXI4-Lite byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, slave response watchdog limit.
REQ-004 SHALL have port ACLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port ARESETN  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  2  per-requester access request, bit n = requester n.
REQ-007 SHALL have port we  input  2  per-requester 1=write, 0=read.
REQ-008 SHALL have port addr  input  2*ADDR_WIDTH  per-requester address, requester n at [n*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port wdata  input  2*DATA_WIDTH  per-requester write data.
REQ-010 SHALL have port ack  output  2  one-cycle completion pulse per requester.
REQ-011 SHALL have port rdata  output  DATA_WIDTH  read data, valid while ack is high.
REQ-012 SHALL have port resp  output  2  AXI response code, valid while ack is high.
REQ-013 SHALL have ports m_axi_awaddr/awvalid (out), m_axi_awready (in): write-address channel.
REQ-014 SHALL have ports m_axi_wdata/wstrb/wvalid (out), m_axi_wready (in): write-data channel.
REQ-015 SHALL have ports m_axi_bresp/bvalid (in), m_axi_bready (out): write-response channel.
REQ-016 SHALL have ports m_axi_araddr/arvalid (out), m_axi_arready (in): read-address channel.
REQ-017 SHALL have ports m_axi_rdata/rresp/rvalid (in), m_axi_rready (out): read-data channel.

Function
REQ-018 SHALL implement FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-019 SHALL in IDLE grant round-robin: single req wins; both asserted -> requester not granted last; pointer updates on each grant; after reset requester 0 has priority.
REQ-020 SHALL register granted addr/wdata/we on grant and go to WR_ADDR_DATA (we=1) or RD_ADDR (we=0) the next cycle.
REQ-021 SHALL in WR_ADDR_DATA assert awvalid and wvalid together, dropping each independently on its own ready handshake; wstrb all ones; leave when both accepted (same or different cycles).
REQ-022 SHALL in WR_RESP hold bready=1, capture bresp on bvalid, go to DONE.
REQ-023 SHALL in RD_ADDR hold arvalid until arready, then RD_DATA with rready=1; capture rdata/rresp on rvalid, go to DONE.
REQ-024 SHALL in DONE pulse ack for the granted requester exactly one cycle with rdata/resp valid, then return to IDLE; rdata = 0 for writes.
REQ-025 SHALL ignore req during DONE; requester holds req and fields stable until ack and drops req the cycle after ack, else it is treated as a new request.
REQ-026 SHALL keep valids stable once asserted until handshake (AXI4-Lite compliant); prot fixed 3'b000 internally.
REQ-027 SHALL give minimum latency grant-to-ack of 4 cycles with zero-wait slave ready/response.

Reset
REQ-028 SHALL on ARESETN low force IDLE, all valids/readies/ack low, rdata/resp 0, priority pointer to requester 0, mid-transaction state discarded.
REQ-029 SHALL leave reset synchronously to ACLK, first grant no earlier than first rising edge after ARESETN high.

Configuration
REQ-030 SHALL with TAR_ARB_TIMEOUT_EN defined count cycles in WR_ADDR_DATA/WR_RESP/RD_ADDR/RD_DATA, on reaching TIMEOUT_CYCLES drop all valids/readies, go to DONE, ack with resp=2'b10; counter clears on every state entry.
REQ-031 SHALL without TAR_ARB_TIMEOUT_EN wait indefinitely; TIMEOUT_CYCLES unused; no counter logic.

Verification
REQ-032 SHALL test: r0 write 0x00000001 to 0x0, then r0 read 0x0 -> ack[0] pulses, rdata=0x00000001, resp=0.
REQ-033 SHALL test: req=2'b11 same cycle, r0 write 0x4=0xA5, r1 write 0x8=0x5A -> r0 granted first, then r1; readback matches both.
REQ-034 SHALL test: awready 3 cycles before wready, then reversed -> single write each, no repeated valid, correct bresp.
REQ-035 SHALL test: ARESETN low during RD_DATA -> outputs zero, IDLE, next read to 0xC completes normally.
REQ-036 SHALL test (TAR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): slave never raises arready -> ack after 16 wait cycles, resp=2'b10.

Source files
------------

// File: rtl/tar_axil_arbiter.sv
// tar_axil_arbiter: two-requester round-robin front end driving one AXI4-Lite
// master port. One transaction in flight at a time; completion is signalled by a
// one-cycle ack to the granted requester with read data and response code.
// Optional slave-response watchdog: define TAR_ARB_TIMEOUT_EN.
module tar_axil_arbiter #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [1:0]                req,
  input  logic [1:0]                we,
  input  logic [2*ADDR_WIDTH-1:0]   addr,
  input  logic [2*DATA_WIDTH-1:0]   wdata,
  output logic [1:0]                ack,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                resp,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic                    gnt_q, gnt_d;     // requester currently served
  logic                    prio_q, prio_d;   // requester that wins a tie
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic                    gsel;

`ifdef TAR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`else
  logic                    unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // A lone request wins outright; on a tie the requester not served last wins.
  assign gsel = (req[0] && req[1]) ? prio_q : req[1];

  // State and datapath registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      prio_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
`ifdef TAR_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      prio_q    <= prio_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
`ifdef TAR_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Next-state, grant capture and response capture.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    prio_d    = prio_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d     = gsel;
          prio_d    = ~gsel;
          we_d      = gsel ? we[1] : we[0];
          addr_d    = gsel ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
          wdata_d   = gsel ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (gsel ? we[1] : we[0]) ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
        if (m_axi_wvalid && m_axi_wready)   w_done_d  = 1'b1;
        // Each channel counts as accepted if it completed earlier or completes now.
        if ((aw_done_q || m_axi_awready) && (w_done_q || m_axi_wready)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = m_axi_rresp;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef TAR_ARB_TIMEOUT_EN
    cnt_d = '0;
    if (state_q inside {WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA}) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = DONE;
        resp_d  = 2'b10;
        rdata_d = '0;
      end else if (state_d == state_q) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  // Channel handshakes and requester outputs decoded from registered state.
  always_comb begin
    m_axi_awaddr  = addr_q;
    m_axi_araddr  = addr_q;
    m_axi_wdata   = wdata_q;
    m_axi_wstrb   = '1;
    m_axi_awvalid = (state_q == WR_ADDR_DATA) && !aw_done_q;
    m_axi_wvalid  = (state_q == WR_ADDR_DATA) && !w_done_q;
    m_axi_bready  = (state_q == WR_RESP);
    m_axi_arvalid = (state_q == RD_ADDR);
    m_axi_rready  = (state_q == RD_DATA);
    ack           = 2'b00;
    rdata         = '0;
    resp          = '0;
    if (state_q == DONE) begin
      ack   = gnt_q ? 2'b10 : 2'b01;
      rdata = rdata_q;
      resp  = resp_q;
    end
  end

endmodule
